// File: rtl/fp_div.sv
`default_nettype none
// ============================================================================
// Module   : fp_div
// Purpose  : Iterative IEEE-754-style divider, one quotient bit per clock,
//            restoring shift-subtract, valid/ready on both sides.
//            Optional macro FP_DIV_FLAGS_EN adds the registered flags port.
// Revision : 1.0
// ============================================================================
module fp_div #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  localparam int I_WIDTH = E_WIDTH + M_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_WIDTH-1:0] a,
  input  logic [I_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] out
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [3:0]         flags
`endif
);

  localparam int S_WIDTH = M_WIDTH + 1;
  localparam int Q_WIDTH = M_WIDTH + 3;
  localparam int R_WIDTH = M_WIDTH + 2;
  localparam int X_WIDTH = E_WIDTH + 2;
  localparam int C_WIDTH = $clog2(Q_WIDTH + 1);

  localparam logic signed [X_WIDTH-1:0] BIAS      = X_WIDTH'((1 << (E_WIDTH - 1)) - 1);
  localparam logic signed [X_WIDTH-1:0] EXP_MAX   = X_WIDTH'((1 << E_WIDTH) - 1);
  localparam logic signed [X_WIDTH-1:0] EXP_ZERO  = '0;
  localparam logic signed [X_WIDTH-1:0] EXP_ONE   = X_WIDTH'(1);
  localparam logic [C_WIDTH-1:0]        LAST_ITER = C_WIDTH'(Q_WIDTH - 1);
  localparam logic [I_WIDTH-1:0]        QNAN      = {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV   = 3'd1,
    ROUND = 3'd2,
    SPEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [C_WIDTH-1:0]          cnt_q, cnt_d;
  logic [R_WIDTH-1:0]          rem_q, rem_d;
  logic [S_WIDTH-1:0]          div_q, div_d;
  logic [Q_WIDTH-1:0]          q_q, q_d;
  logic signed [X_WIDTH-1:0]   exp_q, exp_d;
  logic                        sign_q, sign_d;
  logic [I_WIDTH-1:0]          spec_res_q, spec_res_d;
  logic [I_WIDTH-1:0]          out_q, out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        in_ready_q, in_ready_d;
`ifdef FP_DIV_FLAGS_EN
  logic [3:0]                  flags_q, flags_d;
  logic [3:0]                  spec_flg_q, spec_flg_d;
  logic [3:0]                  w_spec_flg;
  logic [3:0]                  w_round_flg;
`endif

  // Operand field decode
  logic                        w_sign_a, w_sign_b, w_sign;
  logic [E_WIDTH-1:0]          w_exp_a, w_exp_b;
  logic [M_WIDTH-1:0]          w_man_a, w_man_b;
  logic                        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic signed [X_WIDTH-1:0]   w_exp_init;

  assign w_sign_a   = a[I_WIDTH-1];
  assign w_sign_b   = b[I_WIDTH-1];
  assign w_sign     = w_sign_a ^ w_sign_b;
  assign w_exp_a    = a[I_WIDTH-2 -: E_WIDTH];
  assign w_exp_b    = b[I_WIDTH-2 -: E_WIDTH];
  assign w_man_a    = a[M_WIDTH-1:0];
  assign w_man_b    = b[M_WIDTH-1:0];
  assign w_a_zero   = (w_exp_a == '0);
  assign w_b_zero   = (w_exp_b == '0);
  assign w_a_nan    = (&w_exp_a) && (|w_man_a);
  assign w_b_nan    = (&w_exp_b) && (|w_man_b);
  assign w_a_inf    = (&w_exp_a) && !(|w_man_a);
  assign w_b_inf    = (&w_exp_b) && !(|w_man_b);
  assign w_exp_init = $signed({2'b00, w_exp_a}) - $signed({2'b00, w_exp_b}) + BIAS;

  logic               w_spec_hit;
  logic [I_WIDTH-1:0] w_spec_res;

  // Special-case priority chain; flags order is {invalid, div_by_zero, overflow, underflow}
  always_comb begin
    w_spec_hit = 1'b1;
    w_spec_res = '0;
`ifdef FP_DIV_FLAGS_EN
    w_spec_flg = 4'b0000;
`endif
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_spec_res = QNAN;
`ifdef FP_DIV_FLAGS_EN
      w_spec_flg = 4'b1000;
`endif
    end else if (w_b_zero) begin
      w_spec_res = {w_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      w_spec_flg = 4'b0100;
`endif
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = '0;
    end else begin
      w_spec_hit = 1'b0;
    end
  end

  // One restoring step
  logic               w_ge;
  logic [R_WIDTH-1:0] w_diff;

  assign w_ge   = (rem_q >= {1'b0, div_q});
  assign w_diff = w_ge ? (rem_q - {1'b0, div_q}) : rem_q;

  // Normalize, round to nearest even, range check
  logic                      w_norm, w_guard, w_sticky, w_carry;
  logic [S_WIDTH-1:0]        w_kept;
  logic [S_WIDTH:0]          w_rnd;
  logic [M_WIDTH-1:0]        w_frac;
  logic signed [X_WIDTH-1:0] w_exp_n, w_exp_r;
  logic [I_WIDTH-1:0]        w_round_res;

  always_comb begin
    w_norm   = q_q[Q_WIDTH-1];
    w_kept   = w_norm ? q_q[Q_WIDTH-1 -: S_WIDTH] : q_q[Q_WIDTH-2 -: S_WIDTH];
    w_guard  = w_norm ? q_q[1] : q_q[0];
    w_sticky = (|rem_q) | (w_norm & q_q[0]);
    w_exp_n  = w_norm ? exp_q : (exp_q - EXP_ONE);
    w_rnd    = {1'b0, w_kept} + (S_WIDTH+1)'(w_guard & (w_sticky | w_kept[0]));
    w_carry  = w_rnd[S_WIDTH];
    w_frac   = w_carry ? w_rnd[S_WIDTH-1:1] : w_rnd[M_WIDTH-1:0];
    w_exp_r  = w_carry ? (w_exp_n + EXP_ONE) : w_exp_n;
`ifdef FP_DIV_FLAGS_EN
    w_round_flg = 4'b0000;
`endif
    if (w_exp_r <= EXP_ZERO) begin
      w_round_res = '0;
`ifdef FP_DIV_FLAGS_EN
      w_round_flg = 4'b0001;
`endif
    end else if (w_exp_r >= EXP_MAX) begin
      w_round_res = {sign_q, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      w_round_flg = 4'b0010;
`endif
    end else begin
      w_round_res = {sign_q, w_exp_r[E_WIDTH-1:0], w_frac};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    div_d       = div_q;
    q_d         = q_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    spec_res_d  = spec_res_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef FP_DIV_FLAGS_EN
    flags_d     = flags_q;
    spec_flg_d  = spec_flg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = w_sign;
          in_ready_d = 1'b0;
          if (w_spec_hit) begin
            spec_res_d = w_spec_res;
`ifdef FP_DIV_FLAGS_EN
            spec_flg_d = w_spec_flg;
`endif
            state_d    = SPEC;
          end else begin
            rem_d   = {1'b0, 1'b1, w_man_a};
            div_d   = {1'b1, w_man_b};
            exp_d   = w_exp_init;
            q_d     = '0;
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        q_d   = {q_q[Q_WIDTH-2:0], w_ge};
        rem_d = w_diff << 1;
        if (cnt_q == LAST_ITER) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ROUND: begin
        out_d       = w_round_res;
`ifdef FP_DIV_FLAGS_EN
        flags_d     = w_round_flg;
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      SPEC: begin
        out_d       = spec_res_q;
`ifdef FP_DIV_FLAGS_EN
        flags_d     = spec_flg_q;
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      spec_res_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef FP_DIV_FLAGS_EN
      flags_q     <= 4'b0000;
      spec_flg_q  <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      q_q         <= q_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      spec_res_q  <= spec_res_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef FP_DIV_FLAGS_EN
      flags_q     <= flags_d;
      spec_flg_q  <= spec_flg_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
`ifdef FP_DIV_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule
`default_nettype wire

// File: doc/fp_div.md
# fp_div

Iterative IEEE-754-style floating-point divider. It is the inverse-operation companion to the team's combinational `fp_mul` and shares its number format and special-value conventions. It computes one quotient bit per clock with a restoring shift-subtract datapath. It sits between an operand source and a result sink, with valid/ready handshakes on both sides.

## Interface
- `E_WIDTH`, 8, exponent width
- `M_WIDTH`, 23, stored mantissa width; word width `I_WIDTH = E_WIDTH+M_WIDTH+1`
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operands `a`, `b` valid
- `in_ready`  out  1  divider can accept operands
- `a`  in  I_WIDTH  dividend {sign, exponent, mantissa}
- `b`  in  I_WIDTH  divisor
- `out_valid`  out  1  quotient valid
- `out_ready`  in  1  sink accepts quotient
- `out`  out  I_WIDTH  quotient a/b
- `flags`  out  4  {invalid, div_by_zero, overflow, underflow}; present only with `FP_DIV_FLAGS_EN`

## Operation
- States are IDLE, DIV, ROUND, SPEC and DONE.
- `in_ready` equals (state==IDLE).
- Accepting edge: `in_valid && in_ready` latches sign = s_a^s_b.
  - If a special case applies, go to SPEC.
  - Otherwise load dividend `{1,m_a}`, divisor `{1,m_b}`, exp = e_a − e_b + BIAS (signed, E_WIDTH+2 bits, BIAS = 2^(E_WIDTH−1)−1), clear counter, go to DIV.
- Special cases are evaluated in priority order. Exponent 0 means zero; subnormals are flushed to zero. NaN is `{0, all-ones exp, 1, zeros}`. Inf is `{sign, all-ones exp, zeros}`. Zero is all bits 0.
  1. Either operand NaN → NaN (invalid).
  2. inf/inf → NaN (invalid).
  3. 0/0 → NaN (invalid).
  4. x/0 with x≠0 → Inf (div_by_zero).
  5. inf/finite → Inf.
  6. 0/x or finite/inf → Zero.
- DIV runs M_WIDTH+3 iterations, one per edge.
  - Each iteration: `q = {q, rem>=div}`, `rem = (rem>=div ? rem−div : rem) << 1`.
  - After the last iteration, sticky = (rem != 0); go to ROUND.
- ROUND (one edge):
  - Normalization: if q MSB = 0, shift q left 1 and exp −= 1.
  - Round-to-nearest-even uses guard = next bit below the M_WIDTH+1 kept bits, plus sticky.
  - If the round-up carries out, shift right 1 and exp += 1.
  - Range check: exp ≤ 0 → Zero (underflow). exp ≥ 2^E_WIDTH−1 → Inf (overflow). Otherwise `{sign, exp[E_WIDTH-1:0], frac}`.
  - Register `out`, go to DONE.
- SPEC (one edge): register the special result, go to DONE.
- DONE: `out_valid`=1. `out` and `flags` are held stable until `out_valid && out_ready`, then go to IDLE.
- A new operand is never accepted in the same cycle a result is consumed. `in_ready` rises the edge after the handshake.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, `flags`=0.
- Normal latency: `out_valid` is high after edge E0+M_WIDTH+4 (27 edges for the defaults), where E0 is the accepting edge.
- Special-case latency: `out_valid` is high after edge E0+1.
- Throughput: at most one operation in flight. `in_ready`=0 from E0 until one edge after the result handshake.
- Backpressure: with `out_ready`=0, DONE holds indefinitely with outputs unchanged.
- Reset in any state (mid-DIV, DONE with a pending result) aborts the operation and restores reset values on that edge. The pending result is lost.
- `a`, `b` are sampled only at E0. Later changes have no effect.

## Configuration
- Macro: `FP_DIV_FLAGS_EN`.
- Defined: the `flags` port exists. Flags are registered with `out`, valid with `out_valid`, and cleared on reset.
- Undefined: the `flags` port and its logic are absent. `out` behaviour is identical.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000; `out_valid` after exactly 27 edges, flags 0.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, which checks RNE round-up with the sticky bit set.
- 0x3F800000 / 0x00000000 → 0x7F800000 after 1 edge, flags 0100. 0x00000000 / 0x00000000 → 0x7FC00000, flags 1000.
- 0x7F000000 / 0x00800000 → 0x7F800000, flags 0010. 0x00800000 / 0x7F000000 → 0x00000000, flags 0001.
- Hold `out_ready`=0 for 10 cycles after 0xC0C00000 / 0x40000000 → `out` stays 0xC0400000, `in_ready` stays 0. Raise `out_ready` → one handshake, then `in_ready`=1 on the next edge.
- Assert `rst` at iteration 10 of DIV → next cycle `in_ready`=1, `out_valid`=0. A fresh 6/2 then completes correctly in 27 edges.
